fetch_sequencer: RTL and testbench

//  Program-counter controller in front of the instruction ROM. Holds the PC and sequences

---
 rtl/knips_pkg.sv | 23 ++
 rtl/fetch_sequencer_branch_lut.sv | 31 +++
 rtl/fetch_sequencer.sv | 93 +++++++++
 tb/tb_fetch_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/knips_pkg.sv
// Shared types and constants for the instruction fetch path.
package knips_pkg;

  localparam int A     = 10;
  localparam int OFF_W = 8;
  localparam int LUT_N = 16;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

  // Absolute branch targets, indexed by the decoder's LutIdx field.
  localparam logic [A-1:0] BRANCH_TABLE [LUT_N] = '{
    10'd0,   10'd100, 10'd200, 10'd300,
    10'd37,  10'd512, 10'd640, 10'd700,
    10'd800, 10'd900, 10'd1000, 10'd1020,
    10'd5,   10'd10,  10'd15,  10'd1023
  };

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// Combinational absolute branch-target lookup; indices past the table yield address 0.
module branch_lut
  import knips_pkg::*;
#(
  parameter int ADDR_W = A,
  parameter int IDX_W  = $clog2(LUT_N)
) (
  input  logic [IDX_W-1:0]  lut_idx,
  output logic [ADDR_W-1:0] target
);

  localparam int SEL_W = $clog2(LUT_N);

  logic out_of_range;

  generate
    if (IDX_W > SEL_W) begin : g_wide_idx
      assign out_of_range = |lut_idx[IDX_W-1:SEL_W];
    end else begin : g_exact_idx
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_comb begin
    target = '0;
    if (!out_of_range) begin
      target = ADDR_W'(BRANCH_TABLE[lut_idx[SEL_W-1:0]]);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencing (start, step, branch, stall, halt) for the instruction ROM.
module fetch_sequencer
  import knips_pkg::*;
#(
  parameter int ADDR_W   = A,
  parameter int OFFSET_W = OFF_W,
  parameter int COUNT_W  = CNT_W,
  parameter int IDX_W    = $clog2(LUT_N)
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Stall,
  input  logic                Halt,
  input  logic                BranchTaken,
  input  logic                BranchRel,
  input  logic [OFFSET_W-1:0] Offset,
  input  logic [IDX_W-1:0]    LutIdx,
  output logic [ADDR_W-1:0]   InstAddress,
  output logic                InstValid,
  output logic                Done,
  output logic [COUNT_W-1:0]  CycleCount
);

  fetch_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   lut_target;
  logic [ADDR_W-1:0]   offset_ext;

  branch_lut #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_branch_lut (
    .lut_idx (LutIdx),
    .target  (lut_target)
  );

  assign offset_ext = {{(ADDR_W-OFFSET_W){Offset[OFFSET_W-1]}}, Offset};

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q != {COUNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Stall outranks everything: the instruction is not retired, so its halt/branch waits.
        if (Stall) begin
          pc_d = pc_q;
        end else if (Halt) begin
          state_d = DONE;
        end else if (BranchTaken) begin
          pc_d = BranchRel ? (pc_q + offset_ext) : lut_target;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign InstAddress = pc_q;
  assign InstValid   = (state_q == RUN);
  assign Done        = (state_q == DONE);
  assign CycleCount  = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an arithmetic reference model checked every cycle.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       start, stall, halt, br_taken, br_rel;
  logic [7:0] offset;
  logic [4:0] lut_idx;

  logic [9:0]  addr_a, addr_b;
  logic        valid_a, valid_b, done_a, done_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: 0 idle, 1 running, 2 finished.
  int m_mode;
  int m_pc;
  int m_cnt16;
  int m_cnt4;
  int tbl [16] = '{0, 100, 200, 300, 37, 512, 640, 700, 800, 900, 1000, 1020, 5, 10, 15, 1023};

  fetch_sequencer #(.ADDR_W(10), .OFFSET_W(8), .COUNT_W(16), .IDX_W(5)) dut_a (
    .CLK(clk), .Reset(rst), .Start(start), .Stall(stall), .Halt(halt),
    .BranchTaken(br_taken), .BranchRel(br_rel), .Offset(offset), .LutIdx(lut_idx),
    .InstAddress(addr_a), .InstValid(valid_a), .Done(done_a), .CycleCount(cnt_a)
  );

  fetch_sequencer #(.ADDR_W(10), .OFFSET_W(8), .COUNT_W(4), .IDX_W(5)) dut_b (
    .CLK(clk), .Reset(rst), .Start(start), .Stall(stall), .Halt(halt),
    .BranchTaken(br_taken), .BranchRel(br_rel), .Offset(offset), .LutIdx(lut_idx),
    .InstAddress(addr_b), .InstValid(valid_b), .Done(done_b), .CycleCount(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = 0; m_cnt16 = 0; m_cnt4 = 0;
    end else if (m_mode == 1) begin
      m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
      if (stall) begin
      end else if (halt) m_mode = 2;
      else if (br_taken && br_rel) m_pc = ((m_pc + int'($signed(offset))) % 1024 + 1024) % 1024;
      else if (br_taken) m_pc = (lut_idx < 16) ? tbl[lut_idx] : 0;
      else m_pc = (m_pc + 1) % 1024;
    end else if (start) begin
      m_mode = 1; m_pc = 0; m_cnt16 = 0; m_cnt4 = 0;
    end
  end

  always @(negedge clk) begin
    check("cyc_addr", int'(addr_a), m_pc);
    check("cyc_addr_b", int'(addr_b), m_pc);
    check("cyc_valid", int'(valid_a), int'(m_mode == 1));
    check("cyc_done", int'(done_a), int'(m_mode == 2));
    check("cyc_cnt16", int'(cnt_a), m_cnt16);
    check("cyc_cnt4", int'(cnt_b), m_cnt4);
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic branch(input logic rel, input logic [7:0] off, input logic [4:0] idx);
    br_taken = 1'b1; br_rel = rel; offset = off; lut_idx = idx;
    tick();
    br_taken = 1'b0; br_rel = 1'b0; offset = '0; lut_idx = '0;
  endtask

  int base_cnt;

  initial begin
    rst = 1'b1; start = 0; stall = 0; halt = 0; br_taken = 0; br_rel = 0;
    offset = '0; lut_idx = '0;
    tick(2);
    rst = 1'b0;
    tick();
    check("rst_pc", int'(addr_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_cnt", int'(cnt_a), 0);

    // Start, run 0..5, halt at 5
    start = 1; tick(); start = 0;
    check("start_valid", int'(valid_a), 1);
    check("start_pc", int'(addr_a), 0);
    tick(5);
    check("seq_pc5", int'(addr_a), 5);
    halt = 1; tick(); halt = 0;
    check("halt_done", int'(done_a), 1);
    check("halt_pc", int'(addr_a), 5);
    check("halt_cnt", int'(cnt_a), 6);
    check("halt_valid", int'(valid_a), 0);
    tick(2);
    check("done_hold_pc", int'(addr_a), 5);
    check("done_hold_cnt", int'(cnt_a), 6);

    // Relative and absolute branches, wrap
    start = 1; tick(); start = 0;
    tick(10);
    check("pc10", int'(addr_a), 10);
    branch(1'b1, 8'hFC, 5'd0);
    check("rel_minus4", int'(addr_a), 6);
    branch(1'b0, 8'h00, 5'd11);
    check("lut11", int'(addr_a), 1020);
    branch(1'b1, 8'h07, 5'd0);
    check("rel_wrap", int'(addr_a), 3);
    branch(1'b0, 8'h00, 5'd15);
    check("lut15", int'(addr_a), 1023);
    tick();
    check("seq_wrap", int'(addr_a), 0);
    branch(1'b0, 8'h00, 5'd3);
    check("lut3", int'(addr_a), 300);
    branch(1'b0, 8'h00, 5'd16);
    check("lut16_oob", int'(addr_a), 0);
    tick();
    check("after_oob", int'(addr_a), 1);
    branch(1'b0, 8'h00, 5'd17);
    check("lut17_oob", int'(addr_a), 0);

    // Stall dominates halt and branch
    tick(8);
    check("pc8", int'(addr_a), 8);
    base_cnt = m_cnt16;
    stall = 1; halt = 1; br_taken = 1; br_rel = 1; offset = 8'h05;
    tick(3);
    check("stall_pc", int'(addr_a), 8);
    check("stall_valid", int'(valid_a), 1);
    check("stall_cnt", int'(cnt_a), base_cnt + 3);
    stall = 0;
    tick();
    halt = 0; br_taken = 0; br_rel = 0; offset = '0;
    check("stall_rel_done", int'(done_a), 1);
    check("stall_rel_pc", int'(addr_a), 8);

    // Start held through RUN and DONE, counter saturation
    start = 1;
    tick();
    check("restart_pc", int'(addr_a), 0);
    check("restart_cnt", int'(cnt_a), 0);
    tick(20);
    check("hold_start_pc", int'(addr_a), 20);
    check("hold_start_cnt", int'(cnt_a), 20);
    check("sat_cnt4", int'(cnt_b), 15);
    halt = 1; tick(); halt = 0;
    check("hold_done", int'(done_a), 1);
    check("hold_done_cnt", int'(cnt_a), 21);
    tick();
    check("done_restart_valid", int'(valid_a), 1);
    check("done_restart_pc", int'(addr_a), 0);
    check("done_restart_cnt", int'(cnt_a), 0);
    start = 0;

    // Asynchronous reset mid-run
    tick(37);
    check("pc37", int'(addr_a), 37);
    #3 rst = 1'b1;
    #1;
    check("arst_pc", int'(addr_a), 0);
    check("arst_valid", int'(valid_a), 0);
    check("arst_done", int'(done_a), 0);
    check("arst_cnt", int'(cnt_a), 0);
    tick();
    rst = 1'b0;
    tick(2);
    check("post_rst_idle", int'(valid_a), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
